data_mem_arbiter: RTL and testbench

Arbiter and sequencer for the single data-memory port (`data_mem`) shared by the CPU load/store unit and the debug/boot loader port. Arbitrates requests and checks alignment and range. Drives `data_mem` write, read and word-load controls. Holds address and byte mask through the read-response cycle, because the memory's output shifter decodes the live address. Returns read data or error to the winning requester one cycle after grant.

---
 rtl/data_mem_pkg.sv | 8 +
 rtl/data_mem_arbiter_if.sv | 32 +++
 rtl/data_mem_access_check.sv | 18 +
 rtl/data_mem_arbiter.sv | 82 ++++++++
 tb/tb_data_mem_arbiter.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types and byte-mask constants for the data-memory arbiter.
package data_mem_pkg;
    typedef enum logic {IDLE, RESP} state_t;
    typedef enum logic {REQ_CPU, REQ_DBG} req_t;
    localparam logic [3:0] BYTES_B = 4'b0001;
    localparam logic [3:0] BYTES_H = 4'b0011;
    localparam logic [3:0] BYTES_W = 4'b1111;
endpackage

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: CPU, debug and data_mem buses of the data-memory arbiter.
interface data_mem_arbiter_if #(
    parameter int word_width = 32,
    parameter int num_col    = 4
);
    logic                  cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_err;
    logic [word_width-1:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [num_col-1:0]    cpu_bytes;
    logic                  dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_err;
    logic [word_width-1:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic                  mem_wren, mem_rden, mem_lden;
    logic [word_width-1:0] mem_addr, mem_data_in, mem_ld_addr, mem_ld_data, mem_data_out;
    logic [num_col-1:0]    mem_which_bytes;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_bytes,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_data_out,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
        output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
        output mem_wren, mem_rden, mem_lden, mem_addr, mem_which_bytes,
        output mem_data_in, mem_ld_addr, mem_ld_data
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_bytes,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_data_out,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
        input  mem_wren, mem_rden, mem_lden, mem_addr, mem_which_bytes,
        input  mem_data_in, mem_ld_addr, mem_ld_data
    );
endinterface

// File: rtl/data_mem_access_check.sv
// data_mem_access_check: flags a request legal when mask, alignment and range are all acceptable.
module data_mem_access_check
    import data_mem_pkg::*;
#(
    parameter int word_width      = 32,
    parameter int data_addr_width = 19
) (
    input  logic [word_width-1:0] addr,
    input  logic [3:0]            bytes,
    output logic                  ok
);
    logic [7:0] span;
    // Any lane shifted past bit 3 means the access straddles a word boundary.
    assign span = {4'b0, bytes} << addr[1:0];
    assign ok = (bytes == BYTES_B || bytes == BYTES_H || bytes == BYTES_W)
             && span[7:4] == 4'b0
             && (addr >> data_addr_width) == '0;
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: arbitrates CPU and debug access to data_mem and sequences load responses.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int word_width      = 32,
    parameter int data_addr_width = 19,
    parameter int num_col         = 4,
    parameter int max_wait        = 8
) (
    input logic clk,
    input logic reset,
    data_mem_arbiter_if.slave bus
);
    localparam int WW = $clog2(max_wait + 1);

    state_t                st, st_nx;
    req_t                  own_q;
    logic                  err_q;
    logic [WW-1:0]         wait_cnt;
    logic [word_width-1:0] addr_q;
    logic [num_col-1:0]    mask_q;
    logic cpu_ok, dbg_ok, dbg_pri, cpu_win, dbg_win, cpu_rd, dbg_rd, wr, rd, ld;

    data_mem_access_check #(.word_width(word_width), .data_addr_width(data_addr_width)) u_cpu_chk (
        .addr(bus.cpu_addr), .bytes(bus.cpu_bytes), .ok(cpu_ok)
    );
    data_mem_access_check #(.word_width(word_width), .data_addr_width(data_addr_width)) u_dbg_chk (
        .addr(bus.dbg_addr), .bytes(BYTES_W), .ok(dbg_ok)
    );

    // Debug takes the port when the CPU is quiet or it has starved for max_wait cycles.
    assign dbg_pri = bus.dbg_req && (!bus.cpu_req || wait_cnt == WW'(max_wait));
    assign cpu_win = !reset && st == IDLE && bus.cpu_req && !dbg_pri;
    assign dbg_win = !reset && st == IDLE && dbg_pri;
    assign cpu_rd  = cpu_win && !bus.cpu_we;
    assign dbg_rd  = dbg_win && !bus.dbg_we;
    assign wr      = cpu_win && bus.cpu_we && cpu_ok;
    assign rd      = (cpu_rd && cpu_ok) || (dbg_rd && dbg_ok);
    assign ld      = dbg_win && bus.dbg_we && dbg_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= IDLE;
            own_q    <= REQ_CPU;
            err_q    <= 1'b0;
            wait_cnt <= '0;
            addr_q   <= '0;
            mask_q   <= '0;
        end else begin
            st    <= st_nx;
            err_q <= (cpu_win && !cpu_ok) || (dbg_win && !dbg_ok);
            if (cpu_win || dbg_win) own_q <= dbg_win ? REQ_DBG : REQ_CPU;
            if (!bus.dbg_req || dbg_win) wait_cnt <= '0;
            else if (wait_cnt != WW'(max_wait)) wait_cnt <= wait_cnt + 1'b1;
            // The memory's output shifter decodes the live address, so hold it through RESP.
            if (rd) begin
                addr_q <= dbg_win ? bus.dbg_addr : bus.cpu_addr;
                mask_q <= dbg_win ? '1 : bus.cpu_bytes;
            end
        end
    end

    always_comb begin
        st_nx               = st == RESP ? IDLE : (cpu_rd || dbg_rd) ? RESP : IDLE;
        bus.cpu_gnt         = cpu_win;
        bus.dbg_gnt         = dbg_win;
        bus.mem_wren        = wr;
        bus.mem_rden        = rd;
        bus.mem_lden        = ld;
        bus.mem_addr        = (wr || rd) ? (dbg_win ? bus.dbg_addr : bus.cpu_addr) : addr_q;
        bus.mem_which_bytes = (wr || rd) ? (dbg_win ? '1 : bus.cpu_bytes) : mask_q;
        bus.mem_data_in     = wr ? bus.cpu_wdata : '0;
        bus.mem_ld_addr     = ld ? bus.dbg_addr : '0;
        bus.mem_ld_data     = ld ? bus.dbg_wdata : '0;
        bus.cpu_rvalid      = st == RESP && own_q == REQ_CPU;
        bus.dbg_rvalid      = st == RESP && own_q == REQ_DBG;
        bus.cpu_err         = err_q && own_q == REQ_CPU;
        bus.dbg_err         = err_q && own_q == REQ_DBG;
        bus.cpu_rdata       = (bus.cpu_rvalid && !err_q) ? bus.mem_data_out : '0;
        bus.dbg_rdata       = (bus.dbg_rvalid && !err_q) ? bus.mem_data_out : '0;
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed stimulus with a response scoreboard against a byte-lane memory model.
module tb_data_mem_arbiter;
    typedef struct packed {
        logic        dbg;
        logic        rv;
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic clk = 0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    logic done = 0;
    resp_t exp_q[$];

    data_mem_arbiter_if bus ();
    data_mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // data_mem model: byte lanes written at the edge, read data shifted by the live address.
    logic [31:0] mem [0:(1<<17)-1];
    logic [3:0]  lanes;
    logic [31:0] sd, rw;
    assign lanes = 4'(bus.mem_which_bytes << bus.mem_addr[1:0]);
    assign sd    = bus.mem_data_in << {bus.mem_addr[1:0], 3'b000};
    always_comb begin
        rw = mem[bus.mem_addr[18:2]] >> {bus.mem_addr[1:0], 3'b000};
        bus.mem_data_out = rw & {{8{bus.mem_which_bytes[3]}}, {8{bus.mem_which_bytes[2]}},
                                 {8{bus.mem_which_bytes[1]}}, {8{bus.mem_which_bytes[0]}}};
    end
    always @(posedge clk) begin
        if (bus.mem_wren)
            for (int i = 0; i < 4; i++)
                if (lanes[i]) mem[bus.mem_addr[18:2]][i*8 +: 8] <= sd[i*8 +: 8];
        if (bus.mem_lden) mem[bus.mem_ld_addr[18:2]] <= bus.mem_ld_data;
    end

    function automatic void chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endfunction

    task automatic op(input logic dbg, input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input logic ok, input logic [31:0] rdv);
        logic g;
        g = 0;
        if (dbg) begin
            bus.dbg_req = 1; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
        end else begin
            bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_bytes = b;
        end
        for (int i = 0; i < 20 && !g; i++) begin
            @(negedge clk);
            g = dbg ? bus.dbg_gnt : bus.cpu_gnt;
            if (!g) @(posedge clk);
        end
        chk("grant", 64'(g), 64'(1));
        if (g) begin
            chk("strobes", 64'({bus.mem_wren, bus.mem_rden, bus.mem_lden}),
                64'(!ok ? 3'b000 : !we ? 3'b010 : dbg ? 3'b001 : 3'b100));
            if (ok && !(dbg && we))
                chk("mem_addr_mask", 64'({bus.mem_addr, bus.mem_which_bytes}), 64'({a, dbg ? 4'hf : b}));
            if (ok && dbg && we) chk("ld_bus", {bus.mem_ld_addr, bus.mem_ld_data}, {a, d});
            if (ok && !dbg && we) chk("data_in", 64'(bus.mem_data_in), 64'(d));
            if (!we || !ok) exp_q.push_back(resp_t'({dbg, !we, !ok, ok ? rdv : 32'h0}));
        end
        @(posedge clk); #1;
        bus.cpu_req = 0;
        bus.dbg_req = 0;
    endtask

    initial begin
        reset = 1;
        {bus.cpu_req, bus.cpu_we, bus.cpu_addr, bus.cpu_wdata, bus.cpu_bytes} = '0;
        {bus.dbg_req, bus.dbg_we, bus.dbg_addr, bus.dbg_wdata} = '0;
        @(negedge clk);
        chk("reset_ctrl", 64'({bus.cpu_gnt, bus.dbg_gnt, bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_err,
                               bus.dbg_err, bus.mem_wren, bus.mem_rden, bus.mem_lden}), 64'(0));
        chk("reset_bus", 64'({bus.mem_addr, bus.mem_which_bytes}), 64'(0));
        chk("reset_data", {bus.mem_data_in, bus.cpu_rdata}, 64'(0));
        @(posedge clk); #1 reset = 0;
        fork
            while (!done) begin
                @(negedge clk);
                for (int p = 0; p < 2; p++) begin
                    logic rv, er;
                    logic [31:0] dt;
                    resp_t e;
                    rv = p ? bus.dbg_rvalid : bus.cpu_rvalid;
                    er = p ? bus.dbg_err : bus.cpu_err;
                    dt = p ? bus.dbg_rdata : bus.cpu_rdata;
                    if (rv || er) begin
                        chk("resp_expected", 64'(exp_q.size() != 0), 64'(1));
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk(p ? "dbg_resp" : "cpu_resp", 64'({p[0], rv, er, dt}), 64'(e));
                        end
                    end
                end
            end
            begin
                op(0, 1, 32'h7ffb8, 32'hdeadbeef, 4'hf, 1, 0);
                op(0, 0, 32'h7ffb8, 0, 4'hf, 1, 32'hdeadbeef);
                bus.cpu_req = 1;
                @(negedge clk);
                chk("resp_no_grant", 64'(bus.cpu_gnt), 64'(0));
                @(posedge clk); #1;
                op(0, 0, 32'h7ffb8, 0, 4'hf, 1, 32'hdeadbeef);
                op(0, 1, 32'h102, 32'hbeef, 4'h3, 1, 0);
                op(0, 0, 32'h103, 0, 4'h1, 1, 32'hbe);
                op(0, 0, 32'h103, 0, 4'h3, 0, 0);
                op(0, 0, 32'h100, 0, 4'h5, 0, 0);
                op(0, 0, 32'h101, 0, 4'hf, 0, 0);
                op(0, 0, 32'h80000, 0, 4'hf, 0, 0);
                op(0, 1, 32'h80000, 32'h1, 4'hf, 0, 0);
                @(posedge clk); #1;
                bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h200; bus.cpu_wdata = 32'h55; bus.cpu_bytes = 4'hf;
                bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 32'h40; bus.dbg_wdata = 32'h12345678;
                for (int k = 0; k < 9; k++) begin
                    @(negedge clk);
                    chk("starve_gnt", 64'({bus.cpu_gnt, bus.dbg_gnt}), 64'(k == 8 ? 2'b01 : 2'b10));
                    if (k == 8)
                        chk("starve_ld", 64'({bus.mem_lden, bus.mem_ld_addr}), 64'({1'b1, 32'h40}));
                    @(posedge clk); #1;
                end
                bus.dbg_addr = 32'h44;
                @(negedge clk);
                chk("wait_cleared", 64'({bus.cpu_gnt, bus.dbg_gnt}), 64'(2'b10));
                @(posedge clk); #1;
                bus.cpu_req = 0; bus.dbg_req = 0;
                op(1, 0, 32'h40, 0, 4'hf, 1, 32'h12345678);
                op(1, 0, 32'h42, 0, 4'hf, 0, 0);
                op(1, 1, 32'h80000, 32'h9, 4'hf, 0, 0);
                @(posedge clk); #1;
                bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h7ffb8; bus.cpu_bytes = 4'hf;
                @(negedge clk);
                chk("pre_reset_gnt", 64'({bus.cpu_gnt, bus.mem_rden}), 64'(2'b11));
                @(posedge clk); #1 reset = 1;
                @(negedge clk);
                chk("reset_abort", 64'({bus.cpu_gnt, bus.cpu_rvalid, bus.cpu_err, bus.mem_rden,
                                        bus.mem_addr, bus.mem_which_bytes}), 64'(0));
                chk("reset_rdata", 64'(bus.cpu_rdata), 64'(0));
                @(posedge clk); #1 reset = 0;
                @(negedge clk);
                chk("post_reset_gnt", 64'({bus.cpu_gnt, bus.mem_rden}), 64'(2'b11));
                exp_q.push_back(resp_t'({1'b0, 1'b1, 1'b0, 32'hdeadbeef}));
                @(posedge clk); #1 bus.cpu_req = 0;
                repeat (3) @(posedge clk);
                done = 1;
            end
        join
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
